// File: rtl/centroid_track.sv
// Accumulates hit-pixel coordinates per frame, then bit-serially divides to get the centroid.
// Result appears CNT_W+12 edges after the frame_end edge; frame_end while busy is dropped and flagged.
module centroid_track #(
    parameter int MIN_PIXELS = 16,
    parameter int CNT_W      = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        pixel_hit,
    input  logic        frame_end,
    output logic [10:0] centroid_x,
    output logic [9:0]  centroid_y,
    output logic        found,
    output logic        centroid_valid,
    output logic        busy,
    output logic        overrun
);
    localparam int W  = CNT_W + 11;
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0]    LAST    = IW'(W - 1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ACC, DIV, DONE} state_t;
    state_t state, state_n;

    logic [W-1:0]     sum_x, sum_x_n;
    logic [W-2:0]     sum_y, sum_y_n;
    logic [CNT_W-1:0] count, count_n;
    logic [W-1:0]     quo_x, quo_y;
    logic [CNT_W-1:0] rem_x, rem_y, divisor;
    logic [IW-1:0]    iter;
    logic             skip;
    logic             start, step, commit, ignore;

    logic [CNT_W:0]   try_x, try_y;
    logic             ge_x, ge_y;

    // Saturated count freezes the whole frame so the average stays in range.
    always_comb begin
        sum_x_n = sum_x;
        sum_y_n = sum_y;
        count_n = count;
        if (pixel_hit && count != CNT_MAX) begin
            sum_x_n = sum_x + W'(hcount);
            sum_y_n = sum_y + (W-1)'(vcount);
            count_n = count + CNT_W'(1);
        end
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        ignore  = 1'b0;
        case (state)
            ACC: begin
                if (frame_end) begin
                    start   = 1'b1;
                    state_n = DIV;
                end
            end
            DIV: begin
                step   = 1'b1;
                ignore = frame_end;
                if (iter == LAST) state_n = DONE;
            end
            DONE: begin
                commit  = 1'b1;
                ignore  = frame_end;
                state_n = ACC;
            end
            default: state_n = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACC;
        else       state <= state_n;
    end

    // Restoring step: partial remainder always stays below the divisor,
    // so the subtraction result fits back into CNT_W bits.
    always_comb begin
        try_x = {rem_x, quo_x[W-1]};
        try_y = {rem_y, quo_y[W-1]};
        ge_x  = try_x >= {1'b0, divisor};
        ge_y  = try_y >= {1'b0, divisor};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_x          <= '0;
            sum_y          <= '0;
            count          <= '0;
            quo_x          <= '0;
            quo_y          <= '0;
            rem_x          <= '0;
            rem_y          <= '0;
            divisor        <= '0;
            iter           <= '0;
            skip           <= 1'b0;
            centroid_x     <= '0;
            centroid_y     <= '0;
            found          <= 1'b0;
            centroid_valid <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (start) begin
                quo_x   <= sum_x_n;
                quo_y   <= {1'b0, sum_y_n};
                rem_x   <= '0;
                rem_y   <= '0;
                iter    <= '0;
                skip    <= count_n < MIN_CNT;
                divisor <= (count_n < MIN_CNT) ? CNT_W'(1) : count_n;
                sum_x   <= '0;
                sum_y   <= '0;
                count   <= '0;
            end else begin
                sum_x <= sum_x_n;
                sum_y <= sum_y_n;
                count <= count_n;
            end
            if (step) begin
                rem_x <= ge_x ? CNT_W'(try_x - {1'b0, divisor}) : try_x[CNT_W-1:0];
                rem_y <= ge_y ? CNT_W'(try_y - {1'b0, divisor}) : try_y[CNT_W-1:0];
                quo_x <= {quo_x[W-2:0], ge_x};
                quo_y <= {quo_y[W-2:0], ge_y};
                iter  <= iter + IW'(1);
            end
            if (commit) begin
                found <= !skip;
                if (!skip) begin
                    centroid_x <= quo_x[10:0];
                    centroid_y <= quo_y[9:0];
                end
            end
            centroid_valid <= commit;
            busy           <= (state_n == DIV);
            overrun        <= ignore;
        end
    end
endmodule

// File: tb/tb_centroid_track.sv
// Drives two trackers (MIN_PIXELS 1 and 16) with directed frames and checks them against a frame-level model.
module tb_centroid_track;
    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        pixel_hit, frame_end;

    logic [10:0] cx_a, cx_b;
    logic [9:0]  cy_a, cy_b;
    logic        found_a, found_b, valid_a, valid_b, busy_a, busy_b, ovr_a, ovr_b;

    centroid_track #(.MIN_PIXELS(1), .CNT_W(20)) dut_a (
        .clk(clk), .reset(rst), .hcount(hcount), .vcount(vcount),
        .pixel_hit(pixel_hit), .frame_end(frame_end),
        .centroid_x(cx_a), .centroid_y(cy_a), .found(found_a),
        .centroid_valid(valid_a), .busy(busy_a), .overrun(ovr_a));

    centroid_track #(.MIN_PIXELS(16), .CNT_W(20)) dut_b (
        .clk(clk), .reset(rst), .hcount(hcount), .vcount(vcount),
        .pixel_hit(pixel_hit), .frame_end(frame_end),
        .centroid_x(cx_b), .centroid_y(cy_b), .found(found_b),
        .centroid_valid(valid_b), .busy(busy_b), .overrun(ovr_b));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_valid = 0, n_busy = 0, n_ovr = 0, t_valid = 0;

    // Frame-level model: sums per frame, exact integer division at frame end,
    // result published a fixed 32 edges after the accepted frame_end.
    localparam longint CMAX = (64'd1 << 20) - 1;
    longint sx[2], sy[2], cnt[2], qx[2], qy[2];
    int     tleft[2];
    bit     pend[2], skp[2];
    longint e_cx[2], e_cy[2];
    bit     e_found[2], e_valid[2], e_busy[2], e_ovr[2];

    function automatic longint minp(input int i);
        return (i == 0) ? 1 : 16;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            sx[i] = 0; sy[i] = 0; cnt[i] = 0; qx[i] = 0; qy[i] = 0;
            tleft[i] = 0; pend[i] = 0; skp[i] = 0;
            e_cx[i] = 0; e_cy[i] = 0; e_found[i] = 0;
            e_valid[i] = 0; e_busy[i] = 0; e_ovr[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (pixel_hit && cnt[i] < CMAX) begin
                sx[i] += hcount; sy[i] += vcount; cnt[i]++;
            end
            if (pend[i]) tleft[i]--;
            e_ovr[i]   = frame_end && pend[i];
            e_valid[i] = 0;
            if (pend[i] && tleft[i] == 0) begin
                e_valid[i] = 1;
                e_found[i] = !skp[i];
                if (!skp[i]) begin e_cx[i] = qx[i]; e_cy[i] = qy[i]; end
                pend[i] = 0;
            end
            if (frame_end && !e_ovr[i]) begin
                skp[i] = cnt[i] < minp(i);
                if (!skp[i]) begin qx[i] = sx[i] / cnt[i]; qy[i] = sy[i] / cnt[i]; end
                sx[i] = 0; sy[i] = 0; cnt[i] = 0;
                pend[i] = 1; tleft[i] = 32;
            end
            e_busy[i] = pend[i] && tleft[i] >= 2;
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("a_cx", cx_a, e_cx[0]);       chk("b_cx", cx_b, e_cx[1]);
        chk("a_cy", cy_a, e_cy[0]);       chk("b_cy", cy_b, e_cy[1]);
        chk("a_found", found_a, e_found[0]); chk("b_found", found_b, e_found[1]);
        chk("a_valid", valid_a, e_valid[0]); chk("b_valid", valid_b, e_valid[1]);
        chk("a_busy", busy_a, e_busy[0]); chk("b_busy", busy_b, e_busy[1]);
        chk("a_ovr", ovr_a, e_ovr[0]);    chk("b_ovr", ovr_b, e_ovr[1]);
    endtask

    // One clock: inputs set after the falling edge, sampled at the rising edge, checked at the next falling edge.
    task automatic cycle(input logic h, input int x, input int y, input logic fe);
        pixel_hit = h; hcount = 11'(x); vcount = 10'(y); frame_end = fe;
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        compare_all();
        if (valid_a) begin n_valid++; t_valid = cyc; end
        if (busy_a) n_busy++;
        if (ovr_a) n_ovr++;
        pixel_hit = 1'b0; frame_end = 1'b0;
    endtask

    task automatic hits(input int n, input int x, input int y);
        for (int i = 0; i < n; i++) cycle(1'b1, x, y, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0);
    endtask

    int k, v0, b0, o0;

    initial begin
        model_reset();
        rst = 1'b1; pixel_hit = 1'b0; frame_end = 1'b0; hcount = '0; vcount = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        idle(2);

        // 1: single hit, latency and busy width
        hits(1, 100, 50);
        idle(2);
        v0 = n_valid; b0 = n_busy;
        cycle(1'b0, 0, 0, 1'b1); k = cyc;
        idle(40);
        chk("t1_busy_cycles", n_busy - b0, 31);
        chk("t1_valid_pulses", n_valid - v0, 1);
        chk("t1_latency", t_valid - k, 32);
        chk("t1_cx", cx_a, 100); chk("t1_cy", cy_a, 50); chk("t1_found", found_a, 1);
        chk("t1_b_found", found_b, 0);

        // 2: floor rounding and coordinate extremes
        hits(1, 10, 20); hits(1, 11, 20); hits(1, 10, 21); hits(1, 11, 21);
        cycle(1'b0, 0, 0, 1'b1); idle(40);
        chk("t2_cx", cx_a, 10); chk("t2_cy", cy_a, 20);
        hits(2, 1023, 767);
        cycle(1'b0, 0, 0, 1'b1); idle(40);
        chk("t2_max_cx", cx_a, 1023); chk("t2_max_cy", cy_a, 767);

        // 3: threshold at 16 hits; below threshold holds the prior centroid
        hits(16, 40, 30);
        cycle(1'b0, 0, 0, 1'b1); idle(40);
        chk("t3_pre_cx", cx_b, 40); chk("t3_pre_found", found_b, 1);
        v0 = n_valid;
        hits(15, 500, 300);
        cycle(1'b0, 0, 0, 1'b1); k = cyc; idle(40);
        chk("t3_skip_found", found_b, 0); chk("t3_skip_cx", cx_b, 40); chk("t3_skip_cy", cy_b, 30);
        chk("t3_skip_latency", t_valid - k, 32);
        chk("t3_a_cx", cx_a, 500);
        hits(16, 500, 300);
        cycle(1'b0, 0, 0, 1'b1); idle(40);
        chk("t3_cx", cx_b, 500); chk("t3_cy", cy_b, 300); chk("t3_found", found_b, 1);

        // 4: hit on the frame_end edge belongs to the ending frame
        cycle(1'b1, 200, 100, 1'b1); idle(40);
        chk("t4_cx", cx_a, 200); chk("t4_cy", cy_a, 100);
        hits(1, 2, 4);
        cycle(1'b0, 0, 0, 1'b1); idle(40);
        chk("t4_next_cx", cx_a, 2); chk("t4_next_cy", cy_a, 4);

        // 5: frame_end while busy is dropped and the frames merge
        hits(1, 10, 10);
        v0 = n_valid; o0 = n_ovr;
        cycle(1'b0, 0, 0, 1'b1);
        hits(1, 30, 30);
        idle(3);
        cycle(1'b0, 0, 0, 1'b1);
        idle(40);
        chk("t5_ovr_pulses", n_ovr - o0, 1);
        chk("t5_valid_pulses", n_valid - v0, 1);
        chk("t5_cx", cx_a, 10);
        hits(1, 50, 50);
        cycle(1'b0, 0, 0, 1'b1); idle(40);
        chk("t5_merged_cx", cx_a, 40); chk("t5_merged_cy", cy_a, 40);

        // 6: reset mid-division
        hits(1, 60, 70);
        cycle(1'b0, 0, 0, 1'b1);
        idle(10);
        #1 rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        chk("t6_busy", busy_a, 0); chk("t6_cx", cx_a, 0); chk("t6_found", found_a, 0);
        #1 rst = 1'b0;
        v0 = n_valid;
        idle(40);
        chk("t6_no_valid", n_valid - v0, 0);
        hits(1, 5, 6);
        cycle(1'b0, 0, 0, 1'b1); idle(40);
        chk("t6_fresh_cx", cx_a, 5); chk("t6_fresh_cy", cy_a, 6); chk("t6_fresh_found", found_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
